weight_update: RTL and testbench
================================

WEIGHT_UPDATE -- requirements
Module: weight_update

Interface
REQ-001 SHALL have parameter size, default 3, meaning output-neuron count (length of diff vector).
REQ-002 SHALL have parameter input_size, default 2, meaning previous-layer activation count.
REQ-003 SHALL have parameter data_size, default 16, meaning signed fixed-point word width, data_size/2 fraction bits (Q8.8 at default).
REQ-004 SHALL have parameter learning_rate, default 16'h0020 (0.125), meaning the fixed-point step scale.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port start_valid, input, 1, meaning diff/activation operands are valid.
REQ-008 SHALL have port start_ready, output, 1, meaning the block accepts a job (high only in IDLE).
REQ-009 SHALL have port diff, input, size*data_size, meaning the cost-gradient vector; element k at [(size-k)*data_size-1 -: data_size].
REQ-010 SHALL have port activation, input, input_size*data_size, meaning the previous-layer activations, same slicing.
REQ-011 SHALL have port load_en, input, 1, meaning write load_weights into the weight array.
REQ-012 SHALL have port load_weights, input, size*input_size*data_size, meaning initial weights; w[i][j] at flat index i*input_size+j, MS slice first.
REQ-013 SHALL have port weights, output, size*input_size*data_size, meaning the current weight array, same layout.
REQ-014 SHALL have port busy, output, 1, meaning a job is in progress.
REQ-015 SHALL have port done, output, 1, meaning a single-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SCALE, UPDATE, DONE.
REQ-017 IDLE: on start_valid && start_ready, SHALL register diff and activation, clear counters, and go to SCALE.
REQ-018 SCALE: SHALL spend one cycle per i = 0..size-1 computing sdiff[i] = gdo_mult(learning_rate, diff[i]), then go to UPDATE.
REQ-019 UPDATE: SHALL spend one cycle per (i,j), i outer and j inner, computing w[i][j] <= gdo_sub(w[i][j], gdo_mult(sdiff[i], act[j])), then go to DONE.
REQ-020 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 done SHALL be high in cycle size + size*input_size + 1 after the accepting edge (10 at defaults).
REQ-022 busy SHALL be high in SCALE, UPDATE and DONE; start_ready SHALL equal the IDLE state.
REQ-023 start_valid outside IDLE SHALL be ignored and SHALL NOT queue a job.
REQ-024 Operand inputs SHALL be sampled only at acceptance; later changes SHALL NOT affect the job.
REQ-025 load_en SHALL be honoured only in IDLE and ignored otherwise.
REQ-026 When load_en and acceptance occur in the same cycle, the load SHALL take effect and the job SHALL update the loaded weights.
REQ-027 gdo_mult SHALL be a signed full product with bits [data_size*3/2-1 : data_size/2] kept, wrapping on overflow; gdo_sub SHALL be signed data_size-bit wrapping subtraction (no saturation).
REQ-028 weights SHALL drive the register array directly; intermediate values are visible while busy, and consumers SHALL sample only on done.

Reset
REQ-029 reset SHALL force IDLE, all weights 0, sdiff and captured operands 0, counters 0, done=0, busy=0, start_ready=1.
REQ-030 reset asserted mid-job SHALL abort the job, with no done pulse; outputs SHALL take REQ-029 values the next cycle.
REQ-031 reset SHALL have priority over load_en and start_valid in the same cycle.

Structure
REQ-032 gdo_mult and gdo_sub SHALL come from package gdo; the package SHALL also hold the FRAC_BITS constant and the state enum typedef.
REQ-033 A single shared multiplier SHALL be used; there SHALL be no sub-module.
REQ-034 Counters SHALL be sized $clog2 of size and input_size, minimum 1 bit.

Verification
REQ-035 Reset: after reset, weights all 0, start_ready=1, busy=0, done=0.
REQ-036 Nominal: load w all 0x0100, diff all 0x0200, activation all 0x0100, start -> sdiff 0x0040; all w=0x00C0; done pulses in cycle 10.
REQ-037 Sign: w=0, diff[0]=0xFE00, act[0]=0x0200 -> w[0][0]=0x0080; other weights follow their operands.
REQ-038 Wrap: w[0][0]=0x8000, diff[0]=0x0008, act[0]=0x0100 -> product 0x0001, w[0][0]=0x7FFF.
REQ-039 Busy protection: start_valid and load_en pulsed during UPDATE -> ignored, start_ready=0, a single done, weights unchanged by load.
REQ-040 Abort: reset in the second UPDATE cycle -> next cycle IDLE, weights 0, no done pulse.

Source files
------------

// File: rtl/gdo_pkg.sv
// ============================================================================
//  Module  : gdo (package)
//  Brief   : Fixed-point helpers and FSM state type for the weight updater.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gdo;

    localparam int unsigned FRAC_BITS = 8;
    localparam int          GDO_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCALE  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } gdo_state_t;

    // Operands arrive sign-extended to GDO_MAX_W. The caller keeps the low
    // word of the result, which equals product bits [frac+W-1 : frac].
    function automatic logic signed [GDO_MAX_W-1:0] gdo_mult(
        input logic signed [GDO_MAX_W-1:0] a,
        input logic signed [GDO_MAX_W-1:0] b,
        input int unsigned                 frac = FRAC_BITS
    );
        logic signed [2*GDO_MAX_W-1:0] p;
        p = (2*GDO_MAX_W)'(a) * (2*GDO_MAX_W)'(b);
        return GDO_MAX_W'(p >>> frac);
    endfunction

    function automatic logic signed [GDO_MAX_W-1:0] gdo_sub(
        input logic signed [GDO_MAX_W-1:0] a,
        input logic signed [GDO_MAX_W-1:0] b
    );
        return a - b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/weight_update.sv
// ============================================================================
//  Module  : weight_update
//  Brief   : Sequential gradient-descent weight update, w -= (lr*diff)*act,
//            one shared fixed-point multiplier.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_update
    import gdo::*;
#(
    parameter int                   size          = 3,
    parameter int                   input_size    = 2,
    parameter int                   data_size     = 16,
    parameter logic [data_size-1:0] learning_rate = 16'h0020
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_valid,
    output logic                                  start_ready,
    input  logic [size*data_size-1:0]             diff,
    input  logic [input_size*data_size-1:0]       activation,
    input  logic                                  load_en,
    input  logic [size*input_size*data_size-1:0]  load_weights,
    output logic [size*input_size*data_size-1:0]  weights,
    output logic                                  busy,
    output logic                                  done
);

    localparam int          c_cells  = size * input_size;
    localparam int          c_iw     = (size > 1) ? $clog2(size) : 1;
    localparam int          c_jw     = (input_size > 1) ? $clog2(input_size) : 1;
    localparam int unsigned c_frac   = data_size / 2;
    localparam logic [c_iw-1:0] c_i_last = c_iw'(size - 1);
    localparam logic [c_jw-1:0] c_j_last = c_jw'(input_size - 1);

    typedef logic signed [data_size-1:0] word_t;

    gdo_state_t      r_state;
    gdo_state_t      w_state_next;
    word_t           r_w     [size][input_size];
    word_t           r_sdiff [size];
    word_t           r_diff  [size];
    word_t           r_act   [input_size];
    logic [c_iw-1:0] r_i;
    logic [c_jw-1:0] r_j;

    word_t w_diff_in [size];
    word_t w_act_in  [input_size];
    word_t w_load_in [size][input_size];
    word_t w_mul_a;
    word_t w_mul_b;
    word_t w_prod;
    word_t w_wnew;
    logic  w_accept;
    logic  w_i_last;
    logic  w_j_last;

    // Element k of a flat vector sits most-significant-first.
    for (genvar k = 0; k < size; k++) begin : g_diff
        assign w_diff_in[k] = diff[(size-k)*data_size-1 -: data_size];
    end

    for (genvar k = 0; k < input_size; k++) begin : g_act
        assign w_act_in[k] = activation[(input_size-k)*data_size-1 -: data_size];
    end

    for (genvar i = 0; i < size; i++) begin : g_load_row
        for (genvar j = 0; j < input_size; j++) begin : g_load_col
            assign w_load_in[i][j] =
                load_weights[(c_cells-(i*input_size+j))*data_size-1 -: data_size];
        end
    end

    always_comb begin
        weights = '0;
        for (int i = 0; i < size; i++) begin
            for (int j = 0; j < input_size; j++) begin
                weights[(c_cells-(i*input_size+j))*data_size-1 -: data_size] = r_w[i][j];
            end
        end
    end

    assign w_accept = start_valid && start_ready;
    assign w_i_last = (r_i == c_i_last);
    assign w_j_last = (r_j == c_j_last);

    // The single multiplier scales diff in SCALE and forms the step in UPDATE.
    always_comb begin
        w_mul_a = learning_rate;
        w_mul_b = r_diff[r_i];
        if (r_state == ST_UPDATE) begin
            w_mul_a = r_sdiff[r_i];
            w_mul_b = r_act[r_j];
        end
    end

    assign w_prod = word_t'(gdo_mult(GDO_MAX_W'(w_mul_a), GDO_MAX_W'(w_mul_b), c_frac));
    assign w_wnew = word_t'(gdo_sub(GDO_MAX_W'(r_w[r_i][r_j]), GDO_MAX_W'(w_prod)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)              w_state_next = ST_SCALE;
            ST_SCALE:  if (w_i_last)              w_state_next = ST_UPDATE;
            ST_UPDATE: if (w_i_last && w_j_last)  w_state_next = ST_DONE;
            ST_DONE:                              w_state_next = ST_IDLE;
            default:                              w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE:   start_ready = 1'b1;
            ST_SCALE:  busy        = 1'b1;
            ST_UPDATE: busy        = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default:   start_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < size; i++) begin
                r_sdiff[i] <= '0;
                r_diff[i]  <= '0;
                for (int j = 0; j < input_size; j++) begin
                    r_w[i][j] <= '0;
                end
            end
            for (int j = 0; j < input_size; j++) begin
                r_act[j] <= '0;
            end
            r_i <= '0;
            r_j <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_en) begin
                        r_w <= w_load_in;
                    end
                    if (w_accept) begin
                        r_diff <= w_diff_in;
                        r_act  <= w_act_in;
                        r_i    <= '0;
                        r_j    <= '0;
                    end
                end
                ST_SCALE: begin
                    r_sdiff[r_i] <= w_prod;
                    r_i          <= w_i_last ? '0 : r_i + 1'b1;
                end
                ST_UPDATE: begin
                    r_w[r_i][r_j] <= w_wnew;
                    if (w_j_last) begin
                        r_j <= '0;
                        r_i <= w_i_last ? '0 : r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                    r_i <= '0;
                    r_j <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_weight_update.sv
// ============================================================================
//  Module  : tb_weight_update
//  Brief   : Directed self-checking bench for weight_update against a
//            behavioural fixed-point model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_update;

    localparam int S  = 3;
    localparam int I  = 2;
    localparam int D  = 16;
    localparam int N  = S * I;
    localparam int WB = N * D;
    localparam int J  = S + S * I + 1;
    localparam logic [D-1:0] LR = 16'h0020;

    logic            clk          = 1'b0;
    logic            reset        = 1'b1;
    logic            start_valid  = 1'b0;
    logic            start_ready;
    logic [S*D-1:0]  diff         = '0;
    logic [I*D-1:0]  activation   = '0;
    logic            load_en      = 1'b0;
    logic [WB-1:0]   load_weights = '0;
    logic [WB-1:0]   weights;
    logic            busy;
    logic            done;

    weight_update #(
        .size          (S),
        .input_size    (I),
        .data_size     (D),
        .learning_rate (LR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .diff         (diff),
        .activation   (activation),
        .load_en      (load_en),
        .load_weights (load_weights),
        .weights      (weights),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    task automatic check(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference arithmetic: Q8.8 product with floor shift, wrapped to 16 bits.
    function automatic logic [D-1:0] fx_mul(input logic [D-1:0] a, input logic [D-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return D'(p >>> (D/2));
    endfunction

    function automatic logic [WB-1:0] job_result(input logic [WB-1:0] w,
                                                 input logic [S*D-1:0] dv,
                                                 input logic [I*D-1:0] av);
        logic [WB-1:0] r;
        logic [D-1:0]  sd;
        logic [D-1:0]  cur;
        r = w;
        for (int i = 0; i < S; i++) begin
            sd = fx_mul(LR, dv[(S-i)*D-1 -: D]);
            for (int j = 0; j < I; j++) begin
                cur = r[(N-(i*I+j))*D-1 -: D];
                r[(N-(i*I+j))*D-1 -: D] = cur - fx_mul(sd, av[(I-j)*D-1 -: D]);
            end
        end
        return r;
    endfunction

    function automatic logic [WB-1:0] fill(input logic [D-1:0] v, input int cnt);
        logic [WB-1:0] r;
        r = '0;
        for (int k = 0; k < cnt; k++) r[(cnt-k)*D-1 -: D] = v;
        return r;
    endfunction

    function automatic logic [D-1:0] get_w(input logic [WB-1:0] v, input int f);
        return v[(N-f)*D-1 -: D];
    endfunction

    // Model: job phase 0 = idle, 1..J = in flight, J = done cycle.
    logic [WB-1:0] m_w       = '0;
    logic [WB-1:0] m_pending = '0;
    int            m_phase   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_w     <= '0;
        end else if (m_phase == 0) begin
            if (load_en) m_w <= load_weights;
            if (start_valid) begin
                m_pending <= job_result(load_en ? load_weights : m_w, diff, activation);
                m_phase   <= 1;
            end
        end else if (m_phase == J) begin
            m_phase <= 0;
            m_w     <= m_pending;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        check("busy",        WB'(busy),        WB'(m_phase != 0));
        check("start_ready", WB'(start_ready), WB'(m_phase == 0));
        check("done",        WB'(done),        WB'(m_phase == J));
        if (m_phase == 0)      check("weights_idle", weights, m_w);
        else if (m_phase == J) check("weights_done", weights, m_pending);
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic load_only(input logic [WB-1:0] lw);
        @(negedge clk);
        load_en      = 1'b1;
        load_weights = lw;
        @(negedge clk);
        load_en      = 1'b0;
    endtask

    // Returns at the negedge of the first busy cycle (cyc = 1), operands scrambled.
    task automatic start_job(input logic [S*D-1:0] dv, input logic [I*D-1:0] av,
                             input logic ld, input logic [WB-1:0] lw);
        @(negedge clk);
        diff         = dv;
        activation   = av;
        load_en      = ld;
        load_weights = lw;
        start_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid  = 1'b0;
        load_en      = 1'b0;
        diff         = ~dv;
        activation   = ~av;
        load_weights = ~lw;
        cyc          = 1;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 40) tick();
        check("done_latency", WB'(cyc), WB'(10));
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WB-1:0] lw;
        int            extra;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_weights", weights,          '0);
        check("reset_ready",   WB'(start_ready), WB'(1));
        check("reset_busy",    WB'(busy),        WB'(0));
        check("reset_done",    WB'(done),        WB'(0));
        reset = 1'b0;

        // Nominal: 1.0 - (0.125*2.0)*1.0 = 0.75
        load_only(fill(16'h0100, N));
        start_job((S*D)'(fill(16'h0200, S)), (I*D)'(fill(16'h0100, I)), 1'b0, '0);
        wait_done();
        check("nominal_w", weights, fill(16'h00C0, N));

        // Load coinciding with acceptance: the job works on the loaded weights.
        start_job((S*D)'(fill(16'h0200, S)), (I*D)'(fill(16'h0100, I)), 1'b1, fill(16'h0100, N));
        wait_done();
        check("load_accept_w", weights, fill(16'h00C0, N));

        // Signed operands
        load_only('0);
        start_job({16'hFE00, 16'h0100, 16'h0040}, {16'h0200, 16'hFF00}, 1'b0, '0);
        wait_done();
        check("sign_w00", WB'(get_w(weights, 0)), WB'(16'h0080));
        check("sign_w01", WB'(get_w(weights, 1)), WB'(16'hFFC0));
        check("sign_w10", WB'(get_w(weights, 2)), WB'(16'hFFC0));

        // Wrapping subtraction: 0x8000 - 0x0001
        lw = '0;
        lw[WB-1 -: D] = 16'h8000;
        load_only(lw);
        start_job({16'h0008, 16'h0000, 16'h0000}, {16'h0100, 16'h0000}, 1'b0, '0);
        wait_done();
        check("wrap_w00", WB'(get_w(weights, 0)), WB'(16'h7FFF));

        // Start and load pulsed mid-UPDATE are ignored.
        load_only(fill(16'h0100, N));
        start_job((S*D)'(fill(16'h0200, S)), (I*D)'(fill(16'h0100, I)), 1'b0, '0);
        repeat (4) tick();
        start_valid  = 1'b1;
        load_en      = 1'b1;
        load_weights = fill(16'h1234, N);
        check("busy_ready", WB'(start_ready), WB'(0));
        tick();
        start_valid  = 1'b0;
        load_en      = 1'b0;
        wait_done();
        check("busy_w", weights, fill(16'h00C0, N));
        extra = 0;
        repeat (12) begin
            tick();
            if (done === 1'b1) extra++;
        end
        check("busy_single_done", WB'(extra), WB'(0));

        // Abort in the second UPDATE cycle; reset also beats load and start.
        load_only(fill(16'h0100, N));
        start_job((S*D)'(fill(16'h0200, S)), (I*D)'(fill(16'h0100, I)), 1'b0, '0);
        repeat (4) tick();
        reset        = 1'b1;
        start_valid  = 1'b1;
        load_en      = 1'b1;
        load_weights = fill(16'h5555, N);
        tick();
        check("abort_weights", weights,          '0);
        check("abort_ready",   WB'(start_ready), WB'(1));
        check("abort_busy",    WB'(busy),        WB'(0));
        check("abort_done",    WB'(done),        WB'(0));
        reset       = 1'b0;
        start_valid = 1'b0;
        load_en     = 1'b0;
        extra = 0;
        repeat (12) begin
            tick();
            if (done === 1'b1) extra++;
        end
        check("abort_no_done", WB'(extra), WB'(0));

        repeat (2) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
